alu_rf_pipe: RTL and testbench

Parametrised, pipelined successor to the combined ALU/register-file datapath. A DEPTH×WIDTH register file (two read ports, one write port) feeds an ALU with registered result and flags, a write-back stage with forwarding, and an iterative multi-cycle multiplier behind a valid/ready handshake. It sits between the decoder/control FSM and the memory interface of the CPU core.

---
 rtl/alu_rf_pkg.sv | 8 +
 rtl/alu_rf_pipe_if.sv | 11 +
 rtl/regfile_2r1w.sv | 22 ++
 rtl/alu_rf_pipe.sv | 135 +++++++++++++
 tb/tb_alu_rf_pipe.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/alu_rf_pkg.sv
// alu_rf_pkg: opcodes, flag bit positions and FSM states shared by the ALU/register-file pipeline
package alu_rf_pkg;
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_OR = 4'h2, OP_AND = 4'h3,
                           OP_XOR = 4'h4, OP_MOV = 4'h5, OP_LSH = 4'h6, OP_CMP = 4'h7,
                           OP_MUL = 4'h8;
    localparam int FLAG_C = 0, FLAG_L = 1, FLAG_F = 2, FLAG_Z = 3, FLAG_N = 4;
    typedef enum logic {ST_RUN, ST_MUL} state_t;
endpackage

// File: rtl/alu_rf_pipe_if.sv
// alu_rf_pipe_if: instruction handshake, result/flags and debug read port of alu_rf_pipe
interface alu_rf_pipe_if #(parameter int WIDTH = 16, parameter int ADDR_W = 5);
    logic              in_valid, in_ready, imm_en, regwrite, out_valid;
    logic [3:0]        op;
    logic [ADDR_W-1:0] ra1, ra2, dbg_addr;
    logic [WIDTH-1:0]  imm, result, flagreg, dbg_data;
    modport master (output in_valid, op, ra1, ra2, imm_en, imm, regwrite, dbg_addr,
                    input in_ready, out_valid, result, flagreg, dbg_data);
    modport slave  (input in_valid, op, ra1, ra2, imm_en, imm, regwrite, dbg_addr,
                    output in_ready, out_valid, result, flagreg, dbg_data);
endinterface

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register file with two combinational read ports, a debug read port and one synchronous write
module regfile_2r1w #(parameter int WIDTH = 16, parameter int ADDR_W = 5) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]  wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] da,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    output logic [WIDTH-1:0]  dd
);
    logic [WIDTH-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
        else if (we) mem[wa] <= wd;
    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];
    assign dd  = mem[da];
endmodule

// File: rtl/alu_rf_pipe.sv
// alu_rf_pipe: register file + ALU with registered result/flags, forwarding write-back and shift-add multiplier
module alu_rf_pipe import alu_rf_pkg::*; #(parameter int WIDTH = 16, parameter int ADDR_W = 5) (
    input logic         clk,
    input logic         rst_n,
    alu_rf_pipe_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    state_t               state, state_nx;
    logic [WIDTH-1:0]     result_q, flag_q, wb_data, rd1, rd2, dbg, a, b, amt, sh, alu_res, alu_flg, mul_flg, mp;
    logic [ADDR_W-1:0]    wb_addr, mdst;
    logic                 wb_valid, valid_q, accept, alu_wr, mwr, last;
    logic [WIDTH:0]       sum, diff;
    logic [2*WIDTH-1:0]   mc, acc, acc_nx;
    logic [CW-1:0]        cnt;

    regfile_2r1w #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_rf (
        .clk(clk), .rst_n(rst_n), .we(wb_valid), .wa(wb_addr), .wd(wb_data),
        .ra1(bus.ra1), .ra2(bus.ra2), .da(bus.dbg_addr), .rd1(rd1), .rd2(rd2), .dd(dbg)
    );

    assign bus.in_ready  = state == ST_RUN;
    assign bus.out_valid = valid_q;
    assign bus.result    = result_q;
    assign bus.flagreg   = flag_q;
    assign bus.dbg_data  = dbg;
    assign accept = bus.in_valid & bus.in_ready;
    // the write-back register is one edge from the array, so reads of its target take it directly
    assign a    = (wb_valid && wb_addr == bus.ra1) ? wb_data : rd1;
    assign b    = bus.imm_en ? bus.imm : (wb_valid && wb_addr == bus.ra2) ? wb_data : rd2;
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign amt  = b[WIDTH-1] ? -b : b;
    assign sh   = (amt >= WIDTH'(WIDTH)) ? '0 : b[WIDTH-1] ? a >> amt : a << amt;

    always_comb begin
        alu_res = result_q;
        alu_flg = flag_q;
        alu_wr  = 1'b1;
        case (bus.op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_flg[FLAG_C] = sum[WIDTH];
                alu_flg[FLAG_F] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_flg[FLAG_C] = diff[WIDTH];
                alu_flg[FLAG_F] = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:  alu_res = a | b;
            OP_AND: alu_res = a & b;
            OP_XOR: alu_res = a ^ b;
            OP_MOV: alu_res = b;
            OP_LSH: alu_res = sh;
            OP_CMP: begin
                alu_wr = 1'b0;
                alu_flg[FLAG_Z] = a == b;
                alu_flg[FLAG_L] = a < b;
                alu_flg[FLAG_N] = $signed(a) < $signed(b);
            end
            default: alu_wr = 1'b0;
        endcase
        if (alu_wr) begin
            alu_flg[FLAG_Z] = alu_res == '0;
            alu_flg[FLAG_N] = alu_res[WIDTH-1];
        end
    end

    assign acc_nx = acc + (mp[0] ? mc : '0);
    assign last   = cnt == CW'(WIDTH - 1);

    always_comb begin
        mul_flg = flag_q;
        mul_flg[FLAG_C] = |acc_nx[2*WIDTH-1:WIDTH];
        mul_flg[FLAG_Z] = acc_nx[WIDTH-1:0] == '0;
        mul_flg[FLAG_N] = acc_nx[WIDTH-1];
    end

    always_comb
        state_nx = (state == ST_RUN) ? ((accept && bus.op == OP_MUL) ? ST_MUL : ST_RUN)
                                     : (last ? ST_RUN : ST_MUL);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= ST_RUN;
        else state <= state_nx;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            result_q <= '0;
            flag_q   <= '0;
            valid_q  <= 1'b0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            mc       <= '0;
            mp       <= '0;
            acc      <= '0;
            cnt      <= '0;
            mdst     <= '0;
            mwr      <= 1'b0;
        end else begin
            valid_q  <= 1'b0;
            wb_valid <= 1'b0;
            if (accept && bus.op != OP_MUL) begin
                result_q <= alu_res;
                flag_q   <= alu_flg;
                valid_q  <= 1'b1;
                wb_valid <= alu_wr & bus.regwrite;
                wb_addr  <= bus.ra1;
                wb_data  <= alu_res;
            end
            if (accept && bus.op == OP_MUL) begin
                mc   <= {{WIDTH{1'b0}}, a};
                mp   <= b;
                acc  <= '0;
                cnt  <= '0;
                mdst <= bus.ra1;
                mwr  <= bus.regwrite;
            end
            if (state == ST_MUL) begin
                acc <= acc_nx;
                mc  <= mc << 1;
                mp  <= mp >> 1;
                cnt <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    result_q <= acc_nx[WIDTH-1:0];
                    flag_q   <= mul_flg;
                    valid_q  <= 1'b1;
                    wb_valid <= mwr;
                    wb_addr  <= mdst;
                    wb_data  <= acc_nx[WIDTH-1:0];
                end
            end
        end
endmodule

// File: tb/tb_alu_rf_pipe.sv
// tb_alu_rf_pipe: directed vectors into a scoreboard queue, checked by an independent out_valid monitor
module tb_alu_rf_pipe;
    import alu_rf_pkg::*;
    localparam int W = 16, AW = 5;
    logic clk = 1'b0, rst_n = 1'b0;
    int compared = 0, mismatched = 0, busy = 0;
    logic [2*W-1:0] sb [$];
    string nq [$];
    logic [2*W-1:0] ex;
    string en;

    always #5 clk = ~clk;

    alu_rf_pipe_if #(.WIDTH(W), .ADDR_W(AW)) bus ();
    alu_rf_pipe #(.WIDTH(W), .ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
        end
    endtask

    always @(negedge clk)
        if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected out_valid: result 0x%h flagreg 0x%h, no output expected", bus.result, bus.flagreg);
            end else begin
                ex = sb.pop_front();
                en = nq.pop_front();
                check({en, " result"}, bus.result, ex[2*W-1:W]);
                check({en, " flagreg"}, bus.flagreg, ex[W-1:0]);
            end
        end

    task automatic issue(input logic [3:0] op, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic ie, input logic [W-1:0] im, input logic rw,
                         input logic [W-1:0] er, input logic [W-1:0] ef, input bit push, input string nm);
        @(negedge clk);
        check({nm, " in_ready"}, W'(bus.in_ready), 16'h0001);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.ra1 = r1;
        bus.ra2 = r2;
        bus.imm_en = ie;
        bus.imm = im;
        bus.regwrite = rw;
        if (push) begin
            sb.push_back({er, ef});
            nq.push_back(nm);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic dbg(input logic [AW-1:0] ad, input logic [W-1:0] exp, input string nm);
        @(negedge clk);
        bus.dbg_addr = ad;
        #1 check(nm, bus.dbg_data, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 0; bus.op = '0; bus.ra1 = '0; bus.ra2 = '0;
        bus.imm_en = 0; bus.imm = '0; bus.regwrite = 0; bus.dbg_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("reset result", bus.result, 16'h0000);
        check("reset flagreg", bus.flagreg, 16'h0000);
        check("reset in_ready", W'(bus.in_ready), 16'h0001);
        for (int i = 0; i < 2**AW; i++) dbg(AW'(i), 16'h0000, "reset dbg");
        // overflow into sign bit
        issue(OP_MOV, 1, 0, 1, 16'h7FFF, 1, 16'h7FFF, 16'h0000, 1, "mov r1");
        issue(OP_MOV, 2, 0, 1, 16'h0001, 1, 16'h0001, 16'h0000, 1, "mov r2");
        issue(OP_ADD, 1, 2, 0, 16'h0000, 1, 16'h8000, 16'h0014, 1, "add r1 r2");
        idle(2);
        dbg(1, 16'h8000, "dbg r1");
        // back-to-back forwarding on both read ports
        issue(OP_MOV, 3, 0, 1, 16'h0005, 1, 16'h0005, 16'h0004, 1, "mov r3");
        issue(OP_ADD, 3, 3, 0, 16'h0000, 1, 16'h000A, 16'h0000, 1, "add r3 r3");
        issue(OP_CMP, 3, 0, 1, 16'hFFFF, 1, 16'h000A, 16'h0002, 1, "cmp r3");
        idle(2);
        dbg(3, 16'h000A, "dbg r3");
        // multiply with busy window and forwarded dependent op afterwards
        issue(OP_MOV, 4, 0, 1, 16'h0100, 1, 16'h0100, 16'h0002, 1, "mov r4");
        issue(OP_MUL, 4, 0, 1, 16'h0100, 1, 16'h0000, 16'h000B, 1, "mul r4");
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.op = OP_MOV;
            bus.ra1 = 4;
            bus.imm_en = 1'b1;
            bus.imm = 16'hDEAD;
            bus.regwrite = 1'b1;
            if (!bus.in_ready) busy++;
            @(posedge clk);
        end
        check("mul busy cycles", W'(busy), 16'd16);
        issue(OP_ADD, 4, 0, 1, 16'h0003, 1, 16'h0003, 16'h0002, 1, "add after mul");
        idle(2);
        dbg(4, 16'h0003, "dbg r4");
        // shifts, illegal opcode, subtract borrow
        issue(OP_MOV, 5, 0, 1, 16'h0001, 1, 16'h0001, 16'h0002, 1, "mov r5");
        issue(OP_LSH, 5, 0, 1, 16'hFFFF, 0, 16'h0000, 16'h000A, 1, "lsh -1");
        issue(OP_LSH, 5, 0, 1, 16'h0004, 0, 16'h0010, 16'h0002, 1, "lsh 4");
        issue(OP_LSH, 5, 0, 1, 16'h0010, 0, 16'h0000, 16'h000A, 1, "lsh 16");
        issue(4'hF, 5, 0, 1, 16'h1234, 1, 16'h0000, 16'h000A, 1, "illegal");
        issue(OP_SUB, 5, 0, 1, 16'h0002, 0, 16'hFFFF, 16'h0013, 1, "sub borrow");
        issue(OP_OR, 5, 0, 1, 16'h8000, 0, 16'h8001, 16'h0013, 1, "or");
        idle(2);
        dbg(5, 16'h0001, "dbg r5");
        // reset in the middle of a multiply
        issue(OP_MOV, 6, 0, 1, 16'h0007, 1, 16'h0007, 16'h0003, 1, "mov r6");
        idle(2);
        issue(OP_MUL, 6, 0, 1, 16'h0002, 1, 16'h000E, 16'h0000, 0, "mul r6");
        idle(8);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("midmul in_ready", W'(bus.in_ready), 16'h0001);
        check("midmul result", bus.result, 16'h0000);
        check("midmul flagreg", bus.flagreg, 16'h0000);
        dbg(6, 16'h0000, "midmul dbg r6");
        repeat (24) @(posedge clk);
        check("scoreboard drained", W'(sb.size()), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
